// File: rtl/alu_pkg.sv
// Shared ALU encodings: main-control ALUOp codes, ALU control codes, R-type funct
// values and the multiply/divide sequencer states.
package alu_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_OR    = 3'b101;
  localparam logic [2:0] ALUOP_AND   = 3'b110;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_LUI  = 4'b0011;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SRA  = 4'b1000;
  localparam logic [3:0] CTRL_SRAV = 4'b1001;
  localparam logic [3:0] CTRL_NONE = 4'b1111;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_SRAV  = 6'b000111;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FIN
  } state_t;

  // MULT/MULTU/DIV/DIVU share the prefix 0110; the low two bits become the engine op
  // (bit 0 = unsigned, bit 1 = divide).
  function automatic logic is_md_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide engine: 32 shift-add or restoring steps on
// operand magnitudes, sign fix-up on the final step, owns the HI/LO registers.
module mdu_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;

  logic        is_div_q;
  logic        neg_q;
  logic        neg_r;
  logic        div0_q;
  logic [31:0] raw_a_q;
  logic [31:0] mag_a_q;
  logic [31:0] mag_b_q;
  logic [31:0] upper_q;
  logic [31:0] lower_q;
  logic [5:0]  count_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] upper_nx;
  logic [31:0] lower_nx;
  logic [32:0] sum;
  logic [32:0] rem_try;
  logic [33:0] diff;
  logic [63:0] prod;
  logic [31:0] hi_res;
  logic [31:0] lo_res;

  assign a_s       = a;
  assign b_s       = b;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed && (a_s < 0);
  assign b_neg     = is_signed && (b_s < 0);
  assign a_mag     = neg_if(a_neg, a);
  assign b_mag     = neg_if(b_neg, b);

  // One radix-2 step: shift-add consumes the multiplier LSB-first from lower_q;
  // restoring divide shifts the dividend MSB-first out of lower_q, quotient bits in.
  always_comb begin
    upper_nx = upper_q;
    lower_nx = lower_q;
    sum      = '0;
    rem_try  = '0;
    diff     = '0;
    if (is_div_q) begin
      rem_try = {upper_q, lower_q[31]};
      diff    = {1'b0, rem_try} - {2'b00, mag_b_q};
      if (!diff[33]) begin
        upper_nx = diff[31:0];
        lower_nx = {lower_q[30:0], 1'b1};
      end else begin
        upper_nx = rem_try[31:0];
        lower_nx = {lower_q[30:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, upper_q} + (lower_q[0] ? {1'b0, mag_a_q} : 33'd0);
      upper_nx = sum[32:1];
      lower_nx = {sum[0], lower_q[31:1]};
    end
  end

  always_comb begin
    prod   = {upper_nx, lower_nx};
    hi_res = '0;
    lo_res = '0;
    if (is_div_q) begin
      if (div0_q) begin
        hi_res = raw_a_q;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        hi_res = neg_if(neg_r, upper_nx);
        lo_res = neg_if(neg_q, lower_nx);
      end
    end else begin
      prod   = neg_q ? (~prod + 64'd1) : prod;
      hi_res = prod[63:32];
      lo_res = prod[31:0];
    end
  end

  assign done = step && (count_q == 6'd31);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if (step) begin
      count_q <= count_q + 6'd1;
      if (done) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      is_div_q <= op[1];
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div0_q   <= op[1] && (b == 32'd0);
      raw_a_q  <= a;
      mag_a_q  <= a_mag;
      mag_b_q  <= b_mag;
      upper_q  <= '0;
      lower_q  <= op[1] ? a_mag : b_mag;
    end else if (step) begin
      upper_q <= upper_nx;
      lower_q <= lower_nx;
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode plus the multiply/divide sequencer: stalls the CPU while the
// iterative engine runs and serves MFHI/MFLO reads of HI/LO.
module alu_ctrl_mdu
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  aluop_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic [3:0]  alu_ctrl_o,
  output logic        use_hilo_o,
  output logic [31:0] hilo_o,
  output logic        stall_o
);

  state_t      state_q;
  state_t      state_d;
  logic        rtype;
  logic        md_req;
  logic        mf_hi;
  logic        mf_lo;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always_comb begin
    alu_ctrl_o = CTRL_NONE;
    if (valid_i) begin
      case (aluop_i)
        ALUOP_ADD: alu_ctrl_o = CTRL_ADD;
        ALUOP_SUB: alu_ctrl_o = CTRL_SUB;
        ALUOP_SLT: alu_ctrl_o = CTRL_SLT;
        ALUOP_LUI: alu_ctrl_o = CTRL_LUI;
        ALUOP_OR:  alu_ctrl_o = CTRL_OR;
        ALUOP_AND: alu_ctrl_o = CTRL_AND;
        ALUOP_RTYPE: begin
          case (funct_i)
            FUNCT_ADD:  alu_ctrl_o = CTRL_ADD;
            FUNCT_SUB:  alu_ctrl_o = CTRL_SUB;
            FUNCT_AND:  alu_ctrl_o = CTRL_AND;
            FUNCT_OR:   alu_ctrl_o = CTRL_OR;
            FUNCT_SLT:  alu_ctrl_o = CTRL_SLT;
            FUNCT_SRA:  alu_ctrl_o = CTRL_SRA;
            FUNCT_SRAV: alu_ctrl_o = CTRL_SRAV;
            default:    alu_ctrl_o = CTRL_NONE;
          endcase
        end
        default: alu_ctrl_o = CTRL_NONE;
      endcase
    end
  end

  assign rtype  = valid_i && (aluop_i == ALUOP_RTYPE);
  assign md_req = rtype && is_md_funct(funct_i);
  assign mf_hi  = rtype && (funct_i == FUNCT_MFHI);
  assign mf_lo  = rtype && (funct_i == FUNCT_MFLO);
  assign start  = (state_q == ST_IDLE) && md_req;
  assign busy   = (state_q == ST_BUSY);

  // FIN exists only so the still-held MULT/DIV cannot re-trigger a start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: if (done) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign stall_o    = start || busy;
  assign use_hilo_o = mf_hi || mf_lo;
  assign hilo_o     = mf_hi ? hi : (mf_lo ? lo : 32'd0);

  mdu_iter u_mdu (
    .clk  (clk_i),
    .rst  (rst_i),
    .start(start),
    .step (busy),
    .op   (funct_i[1:0]),
    .a    (src1_i),
    .b    (src2_i),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed plus randomized bench for alu_ctrl_mdu against a plain-arithmetic model.
module tb_alu_ctrl_mdu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  aluop_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [3:0]  alu_ctrl_o;
  logic        use_hilo_o;
  logic [31:0] hilo_o;
  logic        stall_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  always #5 clk = ~clk;

  alu_ctrl_mdu dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .aluop_i   (aluop_i),
    .funct_i   (funct_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .alu_ctrl_o(alu_ctrl_o),
    .use_hilo_o(use_hilo_o),
    .hilo_o    (hilo_o),
    .stall_o   (stall_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {HI,LO} from ordinary integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    case (f)
      6'b011000: begin
        sp = 64'(sa) * 64'(sb);
        return sp;
      end
      6'b011001: return {32'd0, a} * {32'd0, b};
      6'b011010: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    m = model(f, a, b);
    valid_i = 1'b1;
    aluop_i = 3'b010;
    funct_i = f;
    src1_i  = a;
    src2_i  = b;
    for (int i = 0; i < 33; i++) begin
      #3;
      chk($sformatf("md_stall_c%0d", i), 32'(stall_o), 32'd1);
      if (i == 0) chk("md_ctrl_none", 32'(alu_ctrl_o), 32'hF);
      tick();
      src1_i = $urandom;
      src2_i = $urandom;
    end
    #3;
    chk("md_fin_stall", 32'(stall_o), 32'd0);
    tick();
    exp_hi = m[63:32];
    exp_lo = m[31:0];
  endtask

  task automatic read_hilo(input string tag);
    valid_i = 1'b1;
    aluop_i = 3'b010;
    funct_i = 6'b010000;
    #3;
    chk({tag, "_mfhi"}, hilo_o, exp_hi);
    chk({tag, "_use"}, 32'(use_hilo_o), 32'd1);
    chk({tag, "_nostall"}, 32'(stall_o), 32'd0);
    tick();
    funct_i = 6'b010010;
    #3;
    chk({tag, "_mflo"}, hilo_o, exp_lo);
    tick();
    valid_i = 1'b0;
  endtask

  logic [2:0]  dec_op [12];
  logic [5:0]  dec_fn [12];
  logic [3:0]  dec_ex [12];
  logic [5:0]  rnd_f;

  initial begin
    dec_op = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010, 3'b010,
               3'b010, 3'b010, 3'b010, 3'b111};
    dec_fn = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b100000, 6'b100010,
               6'b100100, 6'b100101, 6'b101010, 6'b100000};
    dec_ex = '{4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0010, 4'b0110,
               4'b0000, 4'b0001, 4'b0111, 4'b1111};

    rst_i = 1'b1; valid_i = 1'b0; aluop_i = 3'b000; funct_i = 6'd0;
    src1_i = 32'd0; src2_i = 32'd0;
    repeat (3) tick();
    rst_i = 1'b0;
    #3;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_use", 32'(use_hilo_o), 32'd0);
    chk("rst_hilo", hilo_o, 32'd0);
    chk("rst_ctrl_invalid", 32'(alu_ctrl_o), 32'hF);
    tick();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    read_hilo("rst");

    valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      aluop_i = dec_op[i];
      funct_i = dec_fn[i];
      #3;
      chk($sformatf("dec_%0d", i), 32'(alu_ctrl_o), 32'(dec_ex[i]));
      tick();
    end
    aluop_i = 3'b010;
    funct_i = 6'b000011; #3; chk("dec_sra", 32'(alu_ctrl_o), 32'h8); tick();
    funct_i = 6'b000111; #3; chk("dec_srav", 32'(alu_ctrl_o), 32'h9); tick();
    funct_i = 6'b111111; #3; chk("dec_bad_funct", 32'(alu_ctrl_o), 32'hF); tick();
    funct_i = 6'b010000; #3; chk("dec_mfhi_ctrl", 32'(alu_ctrl_o), 32'hF); tick();
    funct_i = 6'b010010; #3; chk("dec_mflo_ctrl", 32'(alu_ctrl_o), 32'hF); tick();
    valid_i = 1'b0; aluop_i = 3'b000;
    #3; chk("dec_invalid", 32'(alu_ctrl_o), 32'hF);
    aluop_i = 3'b010; funct_i = 6'b010000;
    #3; chk("mf_invalid_use", 32'(use_hilo_o), 32'd0);
    chk("mf_invalid_hilo", hilo_o, 32'd0);
    tick();

    run_md(6'b011000, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg_lo_model", exp_lo, 32'hFFFF_FFEB);
    read_hilo("mult_m3x7");
    run_md(6'b011001, 32'hFFFF_FFFF, 32'd2);
    read_hilo("multu_max_x2");
    run_md(6'b011010, 32'hFFFF_FFF9, 32'd2);
    read_hilo("div_m7_2");
    run_md(6'b011011, 32'd100, 32'd7);
    read_hilo("divu_100_7");
    run_md(6'b011011, 32'd5, 32'd0);
    read_hilo("divu_by0");
    run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    read_hilo("div_ovf");
    run_md(6'b011010, 32'hFFFF_FFF9, 32'd0);
    read_hilo("div_neg_by0");

    for (int k = 0; k < 8; k++) begin
      rnd_f = {4'b0110, 2'($urandom_range(0, 3))};
      run_md(rnd_f, $urandom, (k == 3) ? 32'd0 : ((k % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom));
      read_hilo($sformatf("rnd%0d", k));
    end

    // Back-to-back: second MULT presented in the IDLE cycle right after FIN.
    run_md(6'b011000, 32'd12345, 32'hFFFF_FF00);
    run_md(6'b011001, 32'hDEAD_BEEF, 32'h1234_5678);
    read_hilo("b2b");

    valid_i = 1'b1; aluop_i = 3'b010; funct_i = 6'b011000;
    src1_i = 32'd9; src2_i = 32'd9;
    repeat (11) tick();
    rst_i = 1'b1;
    funct_i = 6'b010000;
    #3;
    chk("rstbusy_stall_during", 32'(stall_o), 32'd1);
    tick();
    rst_i = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    read_hilo("rstbusy");
    run_md(6'b011000, 32'hFFFF_FFFD, 32'd7);
    read_hilo("after_rst_mult");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
